// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan sequencer.
//   - State encodings of the scan FSM (2'd3 is unused and recovers to IDLE).
//   - Width of the settle counter.
package mux_scan_pkg;

    localparam logic [1:0] IDLE_ENC = 2'd0;
    localparam logic [1:0] SCAN_ENC = 2'd1;
    localparam logic [1:0] HOLD_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE = IDLE_ENC,
        SCAN = SCAN_ENC,
        HOLD = HOLD_ENC
    } state_e;

    localparam int SETTLE_W = 4;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Bundle of the sequencer's control, mux and word-handshake signals.
//   master : the sequencer (drives mux select/enable, busy and the word).
//   slave  : the environment (drives start/abort, mux data and ready).
interface mux_scan_sequencer_if #(
    parameter int SEL_WIDTH    = 5,
    parameter int NUM_CHANNELS = 32
);
    logic                    Start_In;
    logic                    Abort_In;
    logic                    Mux_Data_In;
    logic                    Mux_Enable_Out;
    logic [SEL_WIDTH-1:0]    Mux_Select_Out;
    logic                    Busy_Out;
    logic                    Word_Valid_Out;
    logic                    Word_Ready_In;
    logic [NUM_CHANNELS-1:0] Word_Data_Out;

    modport master (
        input  Start_In, Abort_In, Mux_Data_In, Word_Ready_In,
        output Mux_Enable_Out, Mux_Select_Out, Busy_Out, Word_Valid_Out, Word_Data_Out
    );

    modport slave (
        output Start_In, Abort_In, Mux_Data_In, Word_Ready_In,
        input  Mux_Enable_Out, Mux_Select_Out, Busy_Out, Word_Valid_Out, Word_Data_Out
    );
endinterface

// File: rtl/mux_scan_sequencer_timer.sv
// Settle counter for the scan sequencer.
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   clear         : hold the count at 0 (asserted whenever no scan is running)
//   settle_cycles : extra cycles to wait between a select change and its sample
//   sample_stb    : one-cycle strobe, high when the current channel must be sampled
module mux_scan_timer
    import mux_scan_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic [SETTLE_W-1:0] settle_cycles,
    output logic                sample_stb
);

    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] cnt_d;

    // Strobe when the count reaches the settle time; the count restarts after each strobe.
    always_comb begin
        sample_stb = 1'b0;
        cnt_d      = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == settle_cycles) begin
            sample_stb = 1'b1;
            cnt_d      = '0;
        end else begin
            cnt_d = cnt_q + {{(SETTLE_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a 32:1 data mux.
//   Clock_In / Reset_In : clock and synchronous active-high reset
//   bus (master)        : Start/Abort control, mux Select/Enable/Data,
//                         Busy, and the Word valid/ready/data handshake.
// Steps the mux select through all channels, samples each one after the
// settle time, and presents the assembled word until the consumer takes it.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SEL_WIDTH     = 5,
    parameter int NUM_CHANNELS  = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  Clock_In,
    input  logic                  Reset_In,
    mux_scan_sequencer_if.master  bus
);

    localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(NUM_CHANNELS - 1);

    state_e                  state_q, state_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic                    en_q, en_d;
    logic                    busy_q, busy_d;
    logic                    valid_q, valid_d;
    logic [NUM_CHANNELS-1:0] scratch_q, scratch_d;
    logic [NUM_CHANNELS-1:0] word_q, word_d;
    logic                    sample_stb_s;
    logic                    enter_scan_s;

    // The settle counter only runs while scanning, so it is at 0 on scan entry.
    mux_scan_timer u_timer (
        .clk           (Clock_In),
        .rst           (Reset_In),
        .clear         (state_q != SCAN),
        .settle_cycles (SETTLE_W'(SETTLE_CYCLES)),
        .sample_stb    (sample_stb_s)
    );

    // Next-state, select stepping, sample capture and word hand-off.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        en_d         = en_q;
        valid_d      = valid_q;
        scratch_d    = scratch_q;
        word_d       = word_q;
        enter_scan_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Start_In) begin
                    enter_scan_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                // Abort takes priority over a sample or completion on the same edge.
                if (bus.Abort_In) begin
                    state_d   = IDLE;
                    en_d      = 1'b0;
                    sel_d     = '0;
                    scratch_d = '0;
                end else if (sample_stb_s) begin
                    for (int i = 0; i < NUM_CHANNELS; i++) begin
                        if (sel_q == i[SEL_WIDTH-1:0]) begin
                            scratch_d[i] = bus.Mux_Data_In;
                        end else begin
                            scratch_d[i] = scratch_q[i];
                        end
                    end
                    if (sel_q == LAST_SEL) begin
                        word_d  = scratch_d;
                        valid_d = 1'b1;
                        en_d    = 1'b0;
                        sel_d   = '0;
                        state_d = HOLD;
                    end else begin
                        sel_d = sel_q + {{(SEL_WIDTH-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = SCAN;
                end
            end
            HOLD: begin
                if (bus.Word_Ready_In) begin
                    valid_d = 1'b0;
                    if (bus.Start_In) begin
                        enter_scan_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                // Unused encoding behaves as IDLE.
                if (bus.Start_In) begin
                    enter_scan_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        if (enter_scan_s) begin
            state_d   = SCAN;
            sel_d     = '0;
            en_d      = 1'b1;
            scratch_d = '0;
        end else begin
            state_d = state_d;
        end

        busy_d = (state_d == SCAN);
    end

    // State and output registers.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            scratch_q <= '0;
            word_q    <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            scratch_q <= scratch_d;
            word_q    <= word_d;
        end
    end

    assign bus.Mux_Enable_Out = en_q;
    assign bus.Mux_Select_Out = sel_q;
    assign bus.Busy_Out       = busy_q;
    assign bus.Word_Valid_Out = valid_q;
    assign bus.Word_Data_Out  = word_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench: a behavioural 32:1 mux (and an 8:1 mux for a second
// instance with zero settle time) driven by the sequencer.
module tb_mux_scan_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] pat;
    logic [7:0]  pat8;
    int          n_checks;
    int          n_errors;
    int          en_viol8;

    mux_scan_sequencer_if #(.SEL_WIDTH(5), .NUM_CHANNELS(32)) bus  ();
    mux_scan_sequencer_if #(.SEL_WIDTH(5), .NUM_CHANNELS(8))  bus8 ();

    mux_scan_sequencer #(.SEL_WIDTH(5), .NUM_CHANNELS(32), .SETTLE_CYCLES(1)) u_dut (
        .Clock_In (clk),
        .Reset_In (rst),
        .bus      (bus.master)
    );

    mux_scan_sequencer #(.SEL_WIDTH(5), .NUM_CHANNELS(8), .SETTLE_CYCLES(0)) u_dut8 (
        .Clock_In (clk),
        .Reset_In (rst),
        .bus      (bus8.master)
    );

    // Behavioural muxes: tri-stated output when not enabled.
    assign bus.Mux_Data_In  = bus.Mux_Enable_Out  ? pat[bus.Mux_Select_Out]        : 1'bz;
    assign bus8.Mux_Data_In = bus8.Mux_Enable_Out ? pat8[bus8.Mux_Select_Out[2:0]] : 1'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // With zero settle time every scan cycle samples, so enable must be high whenever busy.
    always @(negedge clk) begin
        if (bus8.Busy_Out && !bus8.Mux_Enable_Out) begin
            en_viol8 <= en_viol8 + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Step one clock and land 1 time unit after the edge (drive/sample point).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges until valid is seen (bounded); inst 1 selects the 8-channel DUT.
    task automatic wait_valid(input int inst, output int n);
        logic v;
        n = 0;
        do begin
            step();
            n++;
            v = (inst == 1) ? bus8.Word_Valid_Out : bus.Word_Valid_Out;
        end while (!v && n < 300);
    endtask

    task automatic wait_sel(input int target);
        int n;
        n = 0;
        while (bus.Mux_Select_Out != target[4:0] && n < 300) begin
            step();
            n++;
        end
        check("reach_sel", {27'd0, bus.Mux_Select_Out}, target);
    endtask

    task automatic start_pulse();
        bus.Start_In = 1'b1;
        step();
        bus.Start_In = 1'b0;
    endtask

    initial begin
        int  n;
        logic stable;
        logic seen;
        n_checks = 0;
        n_errors = 0;
        en_viol8 = 0;
        pat  = 32'h0;
        pat8 = 8'h0;
        rst  = 1'b1;
        bus.Start_In       = 1'b0;
        bus.Abort_In       = 1'b0;
        bus.Word_Ready_In  = 1'b1;
        bus8.Start_In      = 1'b0;
        bus8.Abort_In      = 1'b0;
        bus8.Word_Ready_In = 1'b1;

        // Reset state.
        step();
        step();
        check("rst_busy",  {31'd0, bus.Busy_Out},       32'd0);
        check("rst_valid", {31'd0, bus.Word_Valid_Out}, 32'd0);
        check("rst_en",    {31'd0, bus.Mux_Enable_Out}, 32'd0);
        check("rst_sel",   {27'd0, bus.Mux_Select_Out}, 32'd0);
        check("rst_data",  bus.Word_Data_Out,           32'd0);
        rst = 1'b0;
        step();

        // Test 1: full scan, ready already high.
        pat = 32'hA5C3_0F96;
        start_pulse();
        check("t1_busy", {31'd0, bus.Busy_Out},       32'd1);
        check("t1_en",   {31'd0, bus.Mux_Enable_Out}, 32'd1);
        check("t1_sel0", {27'd0, bus.Mux_Select_Out}, 32'd0);
        wait_valid(0, n);
        check("t1_latency", n, 32'd64);
        check("t1_data",    bus.Word_Data_Out, 32'hA5C3_0F96);
        check("t1_en_off",  {31'd0, bus.Mux_Enable_Out}, 32'd0);
        check("t1_busy_off", {31'd0, bus.Busy_Out}, 32'd0);
        step();
        check("t1_valid_drop", {31'd0, bus.Word_Valid_Out}, 32'd0);
        check("t1_data_hold",  bus.Word_Data_Out, 32'hA5C3_0F96);

        // Test 2: consumer stalls for 10 cycles.
        pat = 32'h1234_5678;
        bus.Word_Ready_In = 1'b0;
        start_pulse();
        wait_valid(0, n);
        check("t2_latency", n, 32'd64);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!bus.Word_Valid_Out || bus.Word_Data_Out != 32'h1234_5678) stable = 1'b0;
        end
        check("t2_stable", {31'd0, stable}, 32'd1);
        bus.Word_Ready_In = 1'b1;
        step();
        check("t2_valid_drop", {31'd0, bus.Word_Valid_Out}, 32'd0);
        check("t2_data", bus.Word_Data_Out, 32'h1234_5678);

        // Test 3: abort at select 17.
        pat = 32'hFFFF_FFFF;
        start_pulse();
        wait_sel(17);
        bus.Abort_In = 1'b1;
        step();
        bus.Abort_In = 1'b0;
        check("t3_busy",  {31'd0, bus.Busy_Out},       32'd0);
        check("t3_en",    {31'd0, bus.Mux_Enable_Out}, 32'd0);
        check("t3_sel",   {27'd0, bus.Mux_Select_Out}, 32'd0);
        check("t3_data",  bus.Word_Data_Out,           32'h1234_5678);
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (bus.Word_Valid_Out) seen = 1'b1;
        end
        check("t3_no_valid", {31'd0, seen}, 32'd0);

        // Test 4: start and ready held high, back-to-back scans.
        pat = 32'hDEAD_BEEF;
        bus.Start_In = 1'b1;
        step();
        wait_valid(0, n);
        check("t4_latency1", n, 32'd64);
        check("t4_data1", bus.Word_Data_Out, 32'hDEAD_BEEF);
        pat = 32'h0000_FFFF;
        wait_valid(0, n);
        check("t4_period", n, 32'd65);
        check("t4_data2", bus.Word_Data_Out, 32'h0000_FFFF);
        bus.Start_In = 1'b0;
        step();
        check("t4_idle", {31'd0, bus.Busy_Out}, 32'd0);
        step();

        // Test 5: reset mid-scan, then a clean scan.
        pat = 32'h5555_AAAA;
        start_pulse();
        wait_sel(9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_busy",  {31'd0, bus.Busy_Out},       32'd0);
        check("t5_valid", {31'd0, bus.Word_Valid_Out}, 32'd0);
        check("t5_en",    {31'd0, bus.Mux_Enable_Out}, 32'd0);
        check("t5_sel",   {27'd0, bus.Mux_Select_Out}, 32'd0);
        check("t5_data",  bus.Word_Data_Out,           32'd0);
        step();
        pat = 32'h8001_7FFE;
        start_pulse();
        wait_valid(0, n);
        check("t5_latency", n, 32'd64);
        check("t5_data2", bus.Word_Data_Out, 32'h8001_7FFE);
        step();

        // Test 6: 8 channels, zero settle time.
        pat8 = 8'hB4;
        bus8.Start_In = 1'b1;
        step();
        bus8.Start_In = 1'b0;
        check("t6_sel0", {27'd0, bus8.Mux_Select_Out}, 32'd0);
        check("t6_en",   {31'd0, bus8.Mux_Enable_Out}, 32'd1);
        step();
        check("t6_sel1", {27'd0, bus8.Mux_Select_Out}, 32'd1);
        wait_valid(1, n);
        check("t6_latency", n + 1, 32'd8);
        check("t6_data", {24'd0, bus8.Word_Data_Out}, 32'h0000_00B4);
        check("t6_en_off", {31'd0, bus8.Mux_Enable_Out}, 32'd0);
        step();
        check("t6_valid_drop", {31'd0, bus8.Word_Valid_Out}, 32'd0);
        check("t6_en_viol", en_viol8, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
